md_scheduler: RTL and testbench
===============================

// Module: md_scheduler
// PURPOSE
//  Sequencing controller for the HI/LO multiply/divide resource in the 5-stage pipeline.
//  Accepts md ops from stage E, runs a fixed-latency busy window, commits HI/LO, and
//  raises the md-stall term for stage D.
//  Sits beside the E-stage ALU; hi/lo feed the M-stage RegWD mux (mfhi/mflo).
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (legal 1..15)
//  DIV_CYCLES   10  busy cycles for div/divu (legal 1..15)
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   synchronous, active-low reset
//  E_valid     in   1   E-stage slot holds a real instruction (0 = bubble)
//  E_mdop      in   3   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 none
//  E_rs_val    in   32  forwarded rs value (operand A / mt source)
//  E_rt_val    in   32  forwarded rt value (operand B)
//  D_md_use    in   1   D-stage instr is mult/div/mthi/mtlo/mfhi/mflo
//  start       out  1   comb: E_valid & E_mdop in 1..4 & state==IDLE
//  busy        out  1   registered: state==RUN
//  md_stall    out  1   comb: D_md_use & (start | busy)
//  hi          out  32  architectural HI
//  lo          out  32  architectural LO
//  done        out  1   registered 1-cycle pulse: new HI/LO committed this cycle
//  md_err      out  1   sticky: md op presented in E while busy
// BEHAVIOUR
//  Reset (reset==0 at edge): state IDLE, cnt 0, busy 0, done 0, md_err 0, hi 0, lo 0.
//   Reset mid-RUN aborts the op; result discarded, no done pulse.
//  FSM IDLE:
//   start: latch op, A=E_rs_val, B=E_rt_val; cnt<=N-1 (N per op); -> RUN.
//   mthi (E_valid & op 5): hi<=E_rs_val at edge; no busy, no done.
//   mtlo (E_valid & op 6): lo<=E_rs_val at edge; no busy, no done.
//   op 0/7 or E_valid=0: no change.
//  FSM RUN:
//   cnt decrements each cycle; at edge with cnt==0: commit hi/lo, done<=1, -> IDLE.
//   Timing: start in cycle T -> busy=1 cycles T+1..T+N; hi/lo new and done=1 in T+N+1.
//   E_valid & E_mdop in 1..6 while RUN: op ignored (no latch, no hi/lo write), md_err<=1.
//  Arithmetic (latched operands, 32-bit):
//   mult: {hi,lo} = signed A * signed B (64-bit).
//   multu: {hi,lo} = unsigned A * unsigned B (64-bit).
//   div: lo = A/B truncated toward zero; hi = remainder, sign of A.
//   divu: lo = A/B unsigned; hi = A%B unsigned.
//   B==0 (div/divu): full busy window; done pulses; hi and lo keep previous values.
//   div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//  done is 0 in every cycle other than commit. md_err cleared only by reset.
//  No combinational path from hi/lo to start/busy/md_stall.
// TESTING
//  mult 0xFFFFFFFE*3, N=5: busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1 one cycle.
//  multu 0xFFFFFFFF*2: hi=0x00000001, lo=0xFFFFFFFE.
//  div -7/2, N=10: lo=0xFFFFFFFD, hi=0xFFFFFFFF after exactly 10 busy cycles.
//  divu 7/0, prior hi=lo=0x11: busy 10 cycles, done=1, hi=lo=0x11 unchanged.
//  D_md_use=1 during start and busy -> md_stall=1; D_md_use=0 -> md_stall=0.
//  mthi 0x1234 while IDLE -> hi=0x1234 next cycle, busy stays 0.
//  mtlo while RUN -> lo unchanged, md_err=1 and stays 1.
//  reset=0 at cycle 3 of div -> busy=0, hi=lo=0, no done pulse.

Source files
------------

// File: rtl/md_scheduler.sv
// HI/LO multiply/divide sequencer: takes md ops from stage E, holds a fixed-latency
// busy window, commits HI/LO with a one-cycle done pulse and drives the D-stage md stall.
module md_scheduler #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_valid,
    input  logic [2:0]  E_mdop,
    input  logic [31:0] E_rs_val,
    input  logic [31:0] E_rt_val,
    input  logic        D_md_use,
    output logic        start,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done,
    output logic        md_err
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [3:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic        busy_q, done_q, err_q;

    logic        is_md_op;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_safe, mag_quo, mag_rem;
    logic [31:0] s_quo, s_rem, u_quo, u_rem;
    logic [31:0] res_hi_d, res_lo_d;

    assign start    = E_valid && (E_mdop >= OP_MULT) && (E_mdop <= OP_DIVU) && (state_q == IDLE);
    assign is_md_op = E_valid && (E_mdop >= OP_MULT) && (E_mdop <= OP_MTLO);
    assign busy     = busy_q;
    assign md_stall = D_md_use && (start || busy_q);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign done     = done_q;
    assign md_err   = err_q;

    // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
    assign prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u  = {32'd0, a_q} * {32'd0, b_q};
    assign a_mag   = a_q[31] ? (~a_q + 32'd1) : a_q;
    assign b_mag   = b_q[31] ? (~b_q + 32'd1) : b_q;
    assign b_safe  = (b_q == 32'd0) ? 32'd1 : b_q;
    assign mag_quo = a_mag / ((b_mag == 32'd0) ? 32'd1 : b_mag);
    assign mag_rem = a_mag % ((b_mag == 32'd0) ? 32'd1 : b_mag);
    assign s_quo   = (a_q[31] ^ b_q[31]) ? (~mag_quo + 32'd1) : mag_quo;
    assign s_rem   = a_q[31] ? (~mag_rem + 32'd1) : mag_rem;
    assign u_quo   = a_q / b_safe;
    assign u_rem   = a_q % b_safe;

    // Divide by zero falls through with the current HI/LO so the commit leaves them intact.
    always_comb begin
        res_hi_d = hi_q;
        res_lo_d = lo_q;
        case (op_q)
            OP_MULT:  {res_hi_d, res_lo_d} = prod_s;
            OP_MULTU: {res_hi_d, res_lo_d} = prod_u;
            OP_DIV: begin
                if (b_q != 32'd0) begin
                    res_hi_d = s_rem;
                    res_lo_d = s_quo;
                end
            end
            OP_DIVU: begin
                if (b_q != 32'd0) begin
                    res_hi_d = u_rem;
                    res_lo_d = u_quo;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= E_mdop;
                        a_q     <= E_rs_val;
                        b_q     <= E_rt_val;
                        cnt_q   <= (E_mdop <= OP_MULTU) ? MULT_LAST : DIV_LAST;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else if (E_valid && (E_mdop == OP_MTHI)) begin
                        hi_q <= E_rs_val;
                    end else if (E_valid && (E_mdop == OP_MTLO)) begin
                        lo_q <= E_rs_val;
                    end
                end
                RUN: begin
                    if (is_md_op) begin
                        err_q <= 1'b1;
                    end
                    if (cnt_q == 4'd0) begin
                        hi_q    <= res_hi_d;
                        lo_q    <= res_lo_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_scheduler.sv
// Bench for md_scheduler: a busy-countdown model checked every cycle plus directed
// operations with hand-computed HI/LO values and busy-window lengths.
module tb_md_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_valid;
    logic [2:0]  E_mdop;
    logic [31:0] E_rs_val, E_rt_val;
    logic        D_md_use;
    logic        start, busy, md_stall, done, md_err;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .E_valid(E_valid), .E_mdop(E_mdop),
        .E_rs_val(E_rs_val), .E_rt_val(E_rt_val), .D_md_use(D_md_use),
        .start(start), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo),
        .done(done), .md_err(md_err)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: HI/LO, sticky error, busy cycles still to come, and a result computed at issue.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_rhi = 32'd0, m_rlo = 32'd0;
    bit          m_err = 1'b0, m_done = 1'b0, m_ok = 1'b0;
    int          m_left = 0;

    task automatic model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rh, output logic [31:0] rl);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     t, r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        rh = m_hi;
        rl = m_lo;
        if (op == 3'd1) begin
            t = sa * sb;
            rh = t[63:32];
            rl = t[31:0];
        end else if (op == 3'd2) begin
            t = ua * ub;
            rh = t[63:32];
            rl = t[31:0];
        end else if (op == 3'd3 && b != 32'd0) begin
            t = sa / sb;
            r = sa % sb;
            rh = r[31:0];
            rl = t[31:0];
        end else if (op == 3'd4 && b != 32'd0) begin
            t = ua / ub;
            r = ua % ub;
            rh = r[31:0];
            rl = t[31:0];
        end
    endtask

    always @(negedge clk) begin
        bit          exp_start;
        logic [31:0] rh, rl;
        exp_start = E_valid && (E_mdop >= 3'd1) && (E_mdop <= 3'd4) && (m_left == 0);
        if (m_ok) begin
            chk1("start", start, exp_start);
            chk1("busy", busy, m_left > 0);
            chk1("md_stall", md_stall, D_md_use && (exp_start || m_left > 0));
            chk1("done", done, m_done);
            chk32("hi", hi, m_hi);
            chk32("lo", lo, m_lo);
            chk1("md_err", md_err, m_err);
        end
        if (!reset) begin
            m_ok = 1'b1;
            m_hi = 32'd0;
            m_lo = 32'd0;
            m_err = 1'b0;
            m_done = 1'b0;
            m_left = 0;
        end else if (m_ok) begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (E_valid && E_mdop >= 3'd1 && E_mdop <= 3'd6) m_err = 1'b1;
                m_left--;
                if (m_left == 0) begin
                    m_hi = m_rhi;
                    m_lo = m_rlo;
                    m_done = 1'b1;
                end
            end else if (exp_start) begin
                m_left = (E_mdop <= 3'd2) ? 5 : 10;
                model_result(E_mdop, E_rs_val, E_rt_val, rh, rl);
                m_rhi = rh;
                m_rlo = rl;
            end else if (E_valid && E_mdop == 3'd5) begin
                m_hi = E_rs_val;
            end else if (E_valid && E_mdop == 3'd6) begin
                m_lo = E_rs_val;
            end
        end
    end

    // Each drive call holds its inputs for exactly one cycle, changing them 1 time unit after posedge.
    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic du);
        E_valid = v;
        E_mdop = op;
        E_rs_val = a;
        E_rt_val = b;
        D_md_use = du;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic wait_done(input string name, input int exp_busy);
        int nb;
        bit seen;
        nb = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) nb++;
                idle(1);
            end
        end
        chk1({name, "_done_seen"}, seen, 1'b1);
        chk32({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        drive(1'b1, op, a, b, 1'b0);
        wait_done(name, exp_busy);
        chk32({name, "_hi"}, hi, exp_hi);
        chk32({name, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int nd;
        reset = 1'b0;
        E_valid = 1'b0;
        E_mdop = 3'd0;
        E_rs_val = 32'd0;
        E_rt_val = 32'd0;
        D_md_use = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", md_err, 1'b0);
        chk32("rst_hi", hi, 32'd0);
        chk32("rst_lo", lo, 32'd0);
        reset = 1'b1;

        run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        idle(1);
        chk1("done_one_cycle", done, 1'b0);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        drive(1'b1, 3'd5, 32'h0000_1234, 32'd0, 1'b0);
        chk32("mthi_hi", hi, 32'h0000_1234);
        chk1("mthi_busy", busy, 1'b0);
        drive(1'b1, 3'd5, 32'h11, 32'd0, 1'b0);
        drive(1'b1, 3'd6, 32'h11, 32'd0, 1'b0);
        chk32("mtlo_lo", lo, 32'h11);

        run_op("divu_zero", 3'd4, 32'd7, 32'd0, 10, 32'h11, 32'h11);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
        run_op("mult_nn", 3'd1, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 5, 32'd0, 32'h15);
        run_op("div_negb", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
        run_op("divu_big", 3'd4, 32'hFFFF_FFFF, 32'd10, 10, 32'd5, 32'h1999_9999);

        E_valid = 1'b1; E_mdop = 3'd1; E_rs_val = 32'd2; E_rt_val = 32'd3; D_md_use = 1'b1;
        #1;
        chk1("stall_start", start, 1'b1);
        chk1("stall_in_start", md_stall, 1'b1);
        @(posedge clk);
        #1;
        E_valid = 1'b0; E_mdop = 3'd0;
        #1;
        chk1("stall_in_busy", md_stall, 1'b1);
        D_md_use = 1'b0;
        #1;
        chk1("no_stall_unused", md_stall, 1'b0);
        wait_done("mult_stall", 5);
        chk32("mult_stall_lo", lo, 32'd6);

        drive(1'b1, 3'd1, 32'd1, 32'd1, 1'b0);
        chk1("err_before", md_err, 1'b0);
        drive(1'b1, 3'd6, 32'h0000_DEAD, 32'd0, 1'b0);
        chk1("err_set", md_err, 1'b1);
        chk32("err_lo_kept", lo, 32'd6);
        wait_done("mult_err", 4);
        chk32("mult_err_lo", lo, 32'd1);
        idle(2);
        chk1("err_sticky", md_err, 1'b1);

        drive(1'b1, 3'd3, 32'd100, 32'd3, 1'b0);
        idle(2);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        chk1("abort_busy", busy, 1'b0);
        chk32("abort_hi", hi, 32'd0);
        chk32("abort_lo", lo, 32'd0);
        chk1("abort_err", md_err, 1'b0);
        nd = 0;
        for (int k = 0; k < 15; k++) begin
            if (done) nd++;
            idle(1);
        end
        chk32("abort_no_done", 32'(nd), 32'd0);

        run_op("mult_after", 3'd1, 32'h0001_0000, 32'h0001_0000, 5, 32'd1, 32'd0);
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
